// File: rtl/ram_bist_pkg.sv
// ram_bist_pkg: shared definitions for the RAM BIST controller.
//   - state encoding localparams and the state_t enum built from them
//   - next_phase(): successor of each march phase (W0 -> R0 -> W1 -> R1 -> DRAIN)
package ram_bist_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [STATE_W-1:0] ST_W0    = 3'd1;
    localparam logic [STATE_W-1:0] ST_R0    = 3'd2;
    localparam logic [STATE_W-1:0] ST_W1    = 3'd3;
    localparam logic [STATE_W-1:0] ST_R1    = 3'd4;
    localparam logic [STATE_W-1:0] ST_DRAIN = 3'd5;
    localparam logic [STATE_W-1:0] ST_DONE  = 3'd6;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = ST_IDLE,
        W0    = ST_W0,
        R0    = ST_R0,
        W1    = ST_W1,
        R1    = ST_R1,
        DRAIN = ST_DRAIN,
        DONE  = ST_DONE
    } state_t;

    function automatic state_t next_phase(input state_t s);
        case (s)
            W0:      return R0;
            R0:      return W1;
            W1:      return R1;
            R1:      return DRAIN;
            default: return IDLE;
        endcase
    endfunction

endpackage

// File: rtl/ram_bist_cmp.sv
// ram_bist_cmp: read-data compare and error accumulator.
// The expected value, valid flag and address arrive registered alongside the
// RAM read access; they are delayed one more cycle here so they line up with
// ram_dout, which the RAM returns the cycle after the access.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clr             start of a new test: empties the pipeline and the counters
//   vld, exp, addr  read access in flight (registered alongside the read)
//   dout            RAM read data
//   err_cnt         saturating mismatch count
//   first_fail_addr address of the first mismatch of the test, 0 if none
//   clean           no mismatch so far, including a compare finishing this cycle
module ram_bist_cmp #(
    parameter int A = 4,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         vld,
    input  logic [W-1:0] exp,
    input  logic [A-1:0] addr,
    input  logic [W-1:0] dout,
    output logic [A:0]   err_cnt,
    output logic [A-1:0] first_fail_addr,
    output logic         clean
);

    logic         vld_q;
    logic [W-1:0] exp_q;
    logic [A-1:0] addr_q;
    logic         hit;

    assign hit   = vld_q && (dout != exp_q);
    // Lets the controller latch pass on the same edge as the final compare.
    assign clean = (err_cnt == '0) && !hit;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vld_q           <= 1'b0;
            exp_q           <= '0;
            addr_q          <= '0;
            err_cnt         <= '0;
            first_fail_addr <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so the stage order here does not matter.
            vld_q  <= vld;
            exp_q  <= exp;
            addr_q <= addr;
            if (hit) begin
                if (err_cnt != '1) begin
                    err_cnt <= err_cnt + 1'b1;
                end
                // The counter never returns to zero within a test, so zero means "first".
                if (err_cnt == '0) begin
                    first_fail_addr <= addr_q;
                end
            end
        end
    end

endmodule

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl: march-style BIST for a synchronous single-port RAM.
// Sequence: W0 writes P(a) = a + seed, R0 reads it back, W1 writes ~P(a),
// R1 reads it back, DRAIN lets the last compare finish, DONE pulses done.
// Ports:
//   clk, rst               clock, synchronous active-high reset (beats start)
//   start, seed            begin a test (IDLE only), pattern seed
//   ram_addr/din/cs/wr     RAM access, all registered
//   ram_dout               RAM read data, valid the cycle after a read
//   busy, done, pass       status: running, end-of-test pulse, last test clean
//   err_cnt                saturating mismatch count
//   first_fail_addr        address of the first mismatch, 0 if none
module ram_bist_ctrl
    import ram_bist_pkg::*;
#(
    parameter int N = 16,
    parameter int A = 4,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] seed,
    output logic [A-1:0] ram_addr,
    output logic [W-1:0] ram_din,
    output logic         ram_cs,
    output logic         ram_wr,
    input  logic [W-1:0] ram_dout,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [A:0]   err_cnt,
    output logic [A-1:0] first_fail_addr
);

    localparam logic [A-1:0] LAST = A'(N - 1);

    state_t       state_q, state_d;
    logic [A-1:0] addr_d;
    logic [W-1:0] seed_q, seed_d;
    logic [W-1:0] din_d;
    logic [W-1:0] rd_exp_q, rd_exp_d;
    logic         rd_vld_q, rd_vld_d;
    logic         cs_d, wr_d, busy_d, done_d, pass_d;
    logic         accept;
    logic         cmp_clean;

    function automatic logic [W-1:0] pattern(input logic [A-1:0] a, input logic [W-1:0] s);
        return W'(a) + s;
    endfunction

    // ram_addr doubles as the march address counter: it is 0 whenever no
    // access is in progress, so no separate counter register is needed.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        state_d = state_q;
        addr_d  = ram_addr;
        seed_d  = seed_q;
        pass_d  = pass;
        accept  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    seed_d  = seed;
                    addr_d  = '0;
                    pass_d  = 1'b0;
                    state_d = W0;
                end
            end
            W0, R0, W1, R1: begin
                if (ram_addr == LAST) begin
                    addr_d  = '0;
                    state_d = next_phase(state_q);
                end else begin
                    addr_d = ram_addr + 1'b1;
                end
            end
            DRAIN: begin
                pass_d  = cmp_clean;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are computed from the next state so that, once registered,
        // they line up with the state they belong to.
        cs_d     = 1'b0;
        wr_d     = 1'b0;
        din_d    = '0;
        rd_vld_d = 1'b0;
        rd_exp_d = '0;
        case (state_d)
            W0: begin
                cs_d  = 1'b1;
                wr_d  = 1'b1;
                din_d = pattern(addr_d, seed_d);
            end
            R0: begin
                cs_d     = 1'b1;
                rd_vld_d = 1'b1;
                rd_exp_d = pattern(addr_d, seed_d);
            end
            W1: begin
                cs_d  = 1'b1;
                wr_d  = 1'b1;
                din_d = ~pattern(addr_d, seed_d);
            end
            R1: begin
                cs_d     = 1'b1;
                rd_vld_d = 1'b1;
                rd_exp_d = ~pattern(addr_d, seed_d);
            end
            default: addr_d = '0;
        endcase

        busy_d = (state_d == W0) || (state_d == R0) || (state_d == W1) ||
                 (state_d == R1) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: synchronous reset: rst is only seen at a clock edge and wins over start there.
            state_q  <= IDLE;
            seed_q   <= '0;
            ram_addr <= '0;
            ram_din  <= '0;
            ram_cs   <= 1'b0;
            ram_wr   <= 1'b0;
            rd_vld_q <= 1'b0;
            rd_exp_q <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            pass     <= 1'b0;
        end else begin
            state_q  <= state_d;
            seed_q   <= seed_d;
            ram_addr <= addr_d;
            ram_din  <= din_d;
            ram_cs   <= cs_d;
            ram_wr   <= wr_d;
            rd_vld_q <= rd_vld_d;
            rd_exp_q <= rd_exp_d;
            busy     <= busy_d;
            done     <= done_d;
            pass     <= pass_d;
        end
    end

    ram_bist_cmp #(
        .A (A),
        .W (W)
    ) u_cmp (
        .clk             (clk),
        .rst             (rst),
        .clr             (accept),
        .vld             (rd_vld_q),
        .exp             (rd_exp_q),
        .addr            (ram_addr),
        .dout            (ram_dout),
        .err_cnt         (err_cnt),
        .first_fail_addr (first_fail_addr),
        .clean           (cmp_clean)
    );

endmodule
